// File: rtl/cdb_broadcaster.sv
// Common data bus driver: round-robin pick of one completed result per cycle,
// broadcast on registered primary and lo (HI/LO pair) channels for one cycle.
module cdb_broadcaster #(
  parameter int N_SRC  = 4,
  parameter int ID_W   = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [N_SRC-1:0]        src_valid,
  output logic [N_SRC-1:0]        src_ready,
  input  logic [N_SRC*ID_W-1:0]   src_ref_id,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic [N_SRC-1:0]        src_lo_en,
  input  logic [N_SRC*ID_W-1:0]   src_lo_ref_id,
  input  logic [N_SRC*DATA_W-1:0] src_lo_data,
  output logic                    bus_en,
  output logic [ID_W-1:0]         bus_ref_id,
  output logic [DATA_W-1:0]       bus_data,
  output logic                    bus_lo_en,
  output logic [ID_W-1:0]         bus_lo_ref_id,
  output logic [DATA_W-1:0]       bus_lo_data
);

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [PTR_W-1:0]  rr_ptr_reg;
  logic [PTR_W-1:0]  rr_ptr_next;
  logic              grant_any;
  logic [PTR_W-1:0]  grant_idx;
  int                scan_idx;
  logic [ID_W-1:0]   grant_id;
  logic [DATA_W-1:0] grant_data;
  logic              grant_lo;
  logic [ID_W-1:0]   grant_lo_id;
  logic [DATA_W-1:0] grant_lo_data;

  // First valid source at or after the pointer, wrapping modulo N_SRC.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int off = 0; off < N_SRC; off++) begin
      scan_idx = int'(rr_ptr_reg) + off;
      if (scan_idx >= N_SRC) scan_idx = scan_idx - N_SRC;
      if (!grant_any && src_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(scan_idx);
      end
    end
    if (rst || flush) grant_any = 1'b0;
  end

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_ready
    assign src_ready[gi] = grant_any && (grant_idx == PTR_W'(gi));
  end

  always_comb begin
    grant_id      = src_ref_id[grant_idx*ID_W +: ID_W];
    grant_data    = src_data[grant_idx*DATA_W +: DATA_W];
    grant_lo      = src_lo_en[grant_idx];
    grant_lo_id   = src_lo_ref_id[grant_idx*ID_W +: ID_W];
    grant_lo_data = src_lo_data[grant_idx*DATA_W +: DATA_W];
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_any) begin
      if (grant_idx == PTR_W'(N_SRC - 1)) rr_ptr_next = '0;
      else rr_ptr_next = grant_idx + 1'b1;
    end
  end

  // Bus fields are zeroed whenever nothing is captured, so enables last one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg    <= '0;
      bus_en        <= 1'b0;
      bus_ref_id    <= '0;
      bus_data      <= '0;
      bus_lo_en     <= 1'b0;
      bus_lo_ref_id <= '0;
      bus_lo_data   <= '0;
    end else begin
      rr_ptr_reg    <= rr_ptr_next;
      bus_en        <= grant_any;
      bus_ref_id    <= grant_any ? grant_id : '0;
      bus_data      <= grant_any ? grant_data : '0;
      bus_lo_en     <= grant_any && grant_lo;
      bus_lo_ref_id <= (grant_any && grant_lo) ? grant_lo_id : '0;
      bus_lo_data   <= (grant_any && grant_lo) ? grant_lo_data : '0;
    end
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed plus randomized bench for cdb_broadcaster against a round-robin
// reference model that tracks the pointer as a plain integer.
module tb_cdb_broadcaster;

  localparam int N  = 4;
  localparam int IW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [N-1:0]    src_valid;
  logic [N-1:0]    src_ready;
  logic [N*IW-1:0] src_ref_id;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]    src_lo_en;
  logic [N*IW-1:0] src_lo_ref_id;
  logic [N*DW-1:0] src_lo_data;
  logic            bus_en;
  logic [IW-1:0]   bus_ref_id;
  logic [DW-1:0]   bus_data;
  logic            bus_lo_en;
  logic [IW-1:0]   bus_lo_ref_id;
  logic [DW-1:0]   bus_lo_data;

  logic [IW-1:0] sid[N];
  logic [IW-1:0] slid[N];
  logic [DW-1:0] sdata[N];
  logic [DW-1:0] sldata[N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      src_ref_id[i*IW +: IW]    = sid[i];
      src_data[i*DW +: DW]      = sdata[i];
      src_lo_ref_id[i*IW +: IW] = slid[i];
      src_lo_data[i*DW +: DW]   = sldata[i];
    end
  end

  cdb_broadcaster #(.N_SRC(N), .ID_W(IW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_ref_id(src_ref_id), .src_data(src_data),
    .src_lo_en(src_lo_en), .src_lo_ref_id(src_lo_ref_id), .src_lo_data(src_lo_data),
    .bus_en(bus_en), .bus_ref_id(bus_ref_id), .bus_data(bus_data),
    .bus_lo_en(bus_lo_en), .bus_lo_ref_id(bus_lo_ref_id), .bus_lo_data(bus_lo_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_rr = 0;
  logic primed = 1'b0;
  logic e_en = 1'b0, e_lo_en = 1'b0;
  logic [IW-1:0] e_id = '0, e_lid = '0;
  logic [DW-1:0] e_data = '0, e_ldata = '0;
  logic [N-1:0] last_ready;
  int last_grant;
  int waitc[N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  // One clock cycle: apply controls at negedge, check arbitration, then check the bus.
  task automatic step(input logic r, input logic f);
    int g;
    @(negedge clk);
    rst = r;
    flush = f;
    #1;
    g = (r || f) ? -1 : model_grant(src_valid);
    last_ready = src_ready;
    last_grant = g;
    check("ready", 64'(src_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    if (primed) check("bus_en_hold", 64'(bus_en), 64'(e_en));
    for (int i = 0; i < N; i++) begin
      if (r || !src_valid[i]) waitc[i] = 0;
      else if (!f) begin
        if (src_ready[i]) waitc[i] = 0;
        else begin
          waitc[i]++;
          check("starve", 64'(waitc[i] <= N - 1), 64'd1);
        end
      end
    end
    @(posedge clk);
    #1;
    primed = 1'b1;
    if (r) begin
      {e_en, e_lo_en, e_id, e_data, e_lid, e_ldata} = '0;
      m_rr = 0;
    end else if (g >= 0) begin
      e_en    = 1'b1;
      e_id    = sid[g];
      e_data  = sdata[g];
      e_lo_en = src_lo_en[g];
      e_lid   = src_lo_en[g] ? slid[g] : '0;
      e_ldata = src_lo_en[g] ? sldata[g] : '0;
      m_rr    = (g + 1) % N;
    end else begin
      {e_en, e_lo_en, e_id, e_data, e_lid, e_ldata} = '0;
    end
    check("bus_en", 64'(bus_en), 64'(e_en));
    check("bus_ref_id", 64'(bus_ref_id), 64'(e_id));
    check("bus_data", 64'(bus_data), 64'(e_data));
    check("bus_lo_en", 64'(bus_lo_en), 64'(e_lo_en));
    check("bus_lo_ref_id", 64'(bus_lo_ref_id), 64'(e_lid));
    check("bus_lo_data", 64'(bus_lo_data), 64'(e_ldata));
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    src_valid = '0;
    src_lo_en = '0;
    for (int i = 0; i < N; i++) begin
      sid[i] = IW'(32'h10 + i);
      sdata[i] = DW'(32'hA000 + i);
      slid[i] = IW'(32'h20 + i);
      sldata[i] = DW'(32'hB000 + i);
      waitc[i] = 0;
    end

    // Reset with every source requesting.
    src_valid = 4'b1111;
    step(1'b1, 1'b0);
    check("rst_ready0", 64'(last_ready), 64'd0);
    step(1'b1, 1'b0);
    check("rst_ready1", 64'(last_ready), 64'd0);
    check("rst_bus_en", 64'(bus_en), 64'd0);

    // Round-robin across all four, starting at source 0.
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0);
      check("rr_order", 64'(last_ready), 64'd1 << (k % N));
    end
    src_valid = '0;

    // Single source.
    sid[2] = 32'h5;
    sdata[2] = 32'hDEADBEEF;
    src_valid = 4'b0100;
    step(1'b0, 1'b0);
    check("single_ready", 64'(last_ready), 64'b0100);
    check("single_id", 64'(bus_ref_id), 64'h5);
    check("single_data", 64'(bus_data), 64'hDEADBEEF);
    src_valid = '0;
    step(1'b0, 1'b0);
    check("single_after", 64'(bus_en), 64'd0);

    // Lo channel pair from source 1.
    sid[1] = 32'h3;
    sdata[1] = 32'h1111;
    slid[1] = 32'h4;
    sldata[1] = 32'h2222;
    src_lo_en = 4'b0010;
    src_valid = 4'b0010;
    step(1'b0, 1'b0);
    check("lo_en", 64'(bus_lo_en), 64'd1);
    check("lo_id", 64'(bus_lo_ref_id), 64'h4);
    check("lo_data", 64'(bus_lo_data), 64'h2222);
    src_valid = '0;
    src_lo_en = '0;
    step(1'b0, 1'b0);

    // Flush: previous broadcast stays visible, pointer holds.
    src_valid = 4'b0001;
    step(1'b0, 1'b0);
    src_valid = 4'b0101;
    step(1'b0, 1'b1);
    check("flush_ready", 64'(last_ready), 64'd0);
    check("flush_bus_en", 64'(bus_en), 64'd0);
    step(1'b0, 1'b0);
    check("post_flush", 64'(last_ready), 64'b0100);

    // Wrap from pointer 3 to source 0.
    src_valid = 4'b1001;
    step(1'b0, 1'b0);
    check("wrap3", 64'(last_ready), 64'b1000);
    src_valid = 4'b0001;
    step(1'b0, 1'b0);
    check("wrap0", 64'(last_ready), 64'b0001);
    src_valid = '0;

    // Random traffic: sources hold until accepted, then may reload.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!src_valid[i] && $urandom_range(1, 0) == 1) begin
          src_valid[i] = 1'b1;
          src_lo_en[i] = 1'($urandom_range(1, 0));
          sid[i] = $urandom;
          sdata[i] = $urandom;
          slid[i] = $urandom;
          sldata[i] = $urandom;
        end
      end
      step($urandom_range(49, 0) == 0, $urandom_range(9, 0) == 0);
      if (last_grant >= 0) src_valid[last_grant] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
- Drives the common data bus (CDB) that every reservation-station line and the ROB snoop for operand wake-up.
- Takes completed results from N_SRC functional units over valid/ready handshakes and picks one per cycle by round-robin.
- Broadcasts the winner on registered bus outputs: primary channel, plus a lo channel for HI/LO-pair results from mult/div.
- It is the transmitting end of the bus_en / bus_ref_id / bus_data / bus_lo_* interface that RS lines consume.

Parameters:
- N_SRC, 4, number of result producers (≥2).
- ID_W, 32, width of ref-id fields; matches the RS-side bus_ref_id width (DATA_BUS).
- DATA_W, 32, width of result data.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  pipeline flush: drops the current grant and the next broadcast.
- src_valid  in  N_SRC  per-source result valid.
- src_ready  out  N_SRC  per-source accept; one-hot or zero; combinational.
- src_ref_id  in  N_SRC*ID_W  flattened primary ref ids; source i at [i*ID_W +: ID_W].
- src_data  in  N_SRC*DATA_W  flattened primary data.
- src_lo_en  in  N_SRC  source also carries a lo result.
- src_lo_ref_id  in  N_SRC*ID_W  flattened lo ref ids.
- src_lo_data  in  N_SRC*DATA_W  flattened lo data.
- bus_en  out  1  broadcast valid this cycle.
- bus_ref_id  out  ID_W  broadcast primary ref id.
- bus_data  out  DATA_W  broadcast primary data.
- bus_lo_en  out  1  lo channel valid; never 1 while bus_en is 0.
- bus_lo_ref_id  out  ID_W  broadcast lo ref id.
- bus_lo_data  out  DATA_W  broadcast lo data.

Behaviour:
- Reset (rst=1 at posedge): all bus_* outputs go to 0 and rr_ptr goes to 0. While rst=1, src_ready=0. Reset asserted mid-broadcast kills that broadcast on the next edge.
- Arbitration (combinational):
  - Scan sources rr_ptr, rr_ptr+1, … mod N_SRC.
  - The first one with src_valid=1 is granted, and its src_ready=1; all others are 0.
  - No valid source, or rst=1, or flush=1 -> src_ready=0.
- Handshake:
  - A transfer is src_valid[i] & src_ready[i] at a posedge.
  - A source holds valid and its payload stable until it is accepted.
  - At most one transfer per cycle. Throughput is one result per cycle, with no bubble between back-to-back grants.
- Latency: a transfer at edge k drives the bus outputs from edge k until edge k+1, i.e. exactly one cycle. The RS sees it on edge k+1.
- Output register update at each posedge:
  - If a transfer occurs: bus_en=1, and bus_ref_id/bus_data take the payload. bus_lo_en=src_lo_en[g], and bus_lo_ref_id/bus_lo_data take the lo payload when src_lo_en[g]=1, otherwise 0.
  - If no transfer occurs: bus_en=0 and bus_lo_en=0, and the data/id outputs are cleared to 0.
  - An enable never stays high for two cycles from a single transfer.
- Round-robin pointer: after a grant to source g, rr_ptr <= (g+1) mod N_SRC. With no grant, rr_ptr holds. Wrap from N_SRC-1 to 0.
- flush=1:
  - No grant that cycle.
  - Outputs are cleared at the edge, so an in-flight broadcast registered on the previous edge is still visible for its one cycle; only new captures are blocked.
  - rr_ptr holds.
  - Sources keep their valid lines; dropping them is the units' responsibility.
- Starvation freedom: a continuously valid source is granted within N_SRC cycles.
- Lo-only results are not supported. src_lo_en is ignored unless it accompanies a primary result.

Test Plan:
- Reset: rst=1 for 2 cycles with all src_valid=1 -> src_ready=0, bus_en=0, bus_lo_en=0, all bus data 0. Release -> the first grant goes to source 0.
- Single source: src_valid=4'b0100, ref_id=0x5, data=0xDEADBEEF for one handshake -> src_ready=4'b0100 that cycle. Next cycle bus_en=1, bus_ref_id=0x5, bus_data=0xDEADBEEF, bus_lo_en=0. The cycle after, bus_en=0.
- Round-robin: all four valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3. bus_en stays high for 8 consecutive cycles with the matching ref_ids.
- Lo channel: source 1 presents ref 0x3 / data 0x1111 with lo_en=1, lo ref 0x4 / lo data 0x2222 -> one broadcast with bus_en=1 and bus_lo_en=1 carrying both pairs.
- Flush: sources 0 and 2 valid, flush=1 for 1 cycle -> src_ready=0 and rr_ptr unchanged. The broadcast accepted before the flush still appears for 1 cycle. After the flush, grant resumes at the pre-flush pointer.
- Wrap/starvation: rr_ptr=3, only sources 3 and 0 valid -> grant 3 then 0. Source 0 is never skipped more than N_SRC-1 cycles.
